mem_responder: RTL and testbench

//  Memory-side responder for the processor's mem_ce/we/addr/width/data/ready initiator interface (matcher table lookups).

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/mem_responder_byte_ram.sv | 26 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the table-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_BYTES = 4;

  // Widths above the bus size are served as full-bus accesses.
  function automatic logic [2:0] clamp_width(input logic [3:0] w);
    return (w > 4'(MAX_BYTES)) ? 3'(MAX_BYTES) : w[2:0];
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// Byte-wide table RAM: port A (async read, sync write) for the responder FSM,
// port B (sync write only) for the host. Port A wins a same-address collision.
module byte_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata
);

  logic [7:0] mem [DEPTH];

  assign a_rdata = mem[a_addr];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we && !(a_we && (a_addr == b_addr))) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves 1..4-byte big-endian reads/writes from a byte
// RAM one byte per cycle, then pulses mem_ready_o for one cycle.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 4096,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_width_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  input  logic              host_we_i,
  input  logic [AW-1:0]     host_addr_i,
  input  logic [7:0]        host_data_i,
  output logic              busy_o,
  output state_e            state_o
);

  // Handshake: the initiator holds mem_ce_i with stable request fields until it
  // sees the one-cycle mem_ready_o pulse; the request is captured once in IDLE
  // and mem_ce_i is ignored in DONE so a late-dropping initiator never re-fires.

  state_e            state;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [2:0]        w_q;
  logic [2:0]        w_in;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [1:0]        sel;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^mem_addr_i[ADDR_W-1:AW];
  assign state_o        = state;
  assign w_in           = clamp_width(mem_width_i);

  // Byte cnt lands in lane w-1-cnt, so the first address holds the MSB.
  assign sel       = 2'(w_q - 3'd1 - cnt);
  assign ram_addr  = addr_q + AW'(cnt);
  assign ram_we    = (state == XFER) && we_q;
  assign ram_wdata = wdata_q[{sel, 3'b000} +: 8];

  always_comb begin
    acc_next = acc;
    acc_next[{sel, 3'b000} +: 8] = ram_rdata;
  end

  byte_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .a_we    (ram_we),
    .a_addr  (ram_addr),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_we    (host_we_i),
    .b_addr  (host_addr_i),
    .b_wdata (host_data_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_ready_o <= 1'b0;
      mem_data_o  <= '0;
      busy_o      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      w_q         <= '0;
      cnt         <= '0;
      wdata_q     <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready_o <= 1'b0;
          if (mem_ce_i) begin
            we_q    <= mem_we_i;
            addr_q  <= mem_addr_i[AW-1:0];
            w_q     <= w_in;
            wdata_q <= mem_data_i;
            cnt     <= '0;
            if (!mem_we_i) acc <= '0;
            // Zero-width requests complete without touching the RAM.
            if (w_in == 3'd0) begin
              mem_ready_o <= 1'b1;
              mem_data_o  <= '0;
              state       <= DONE;
            end else begin
              busy_o <= 1'b1;
              state  <= XFER;
            end
          end
        end
        XFER: begin
          cnt <= cnt + 3'd1;
          if (!we_q) acc <= acc_next;
          if (cnt == w_q - 3'd1) begin
            mem_ready_o <= 1'b1;
            if (!we_q) mem_data_o <= acc_next;
            busy_o <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          mem_ready_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a byte-level reference model and an
// expected-data queue checked at every ready pulse.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk;
  logic          rst;
  logic          mem_ce_i;
  logic          mem_we_i;
  logic [31:0]   mem_addr_i;
  logic [3:0]    mem_width_i;
  logic [31:0]   mem_data_i;
  logic [31:0]   mem_data_o;
  logic          mem_ready_o;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [7:0]    host_data_i;
  logic          busy_o;
  state_e        state_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  model_mem [DEPTH];
  logic [31:0] last_rd = '0;

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_width_i (mem_width_i),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .mem_ready_o (mem_ready_o),
    .host_we_i   (host_we_i),
    .host_addr_i (host_addr_i),
    .host_data_i (host_data_i),
    .busy_o      (busy_o),
    .state_o     (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model the whole request edge by edge (edge 1 = sampling edge, byte i at
  // edge i+2) and push the mem_data_o value expected at the ready pulse.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [3:0] width,
                           input logic [31:0] wdata, input int host_edge,
                           input logic [AW-1:0] haddr, input logic [7:0] hdata,
                           output int lat);
    int w;
    logic [31:0] acc;
    logic [AW-1:0] fa;
    logic fsm_w;
    w   = (width > 4'd4) ? 4 : int'(width);
    acc = '0;
    for (int e = 1; e <= w + 1; e++) begin
      fsm_w = 1'b0;
      fa    = '0;
      if (e >= 2) begin
        fa = AW'(addr[AW-1:0] + AW'(e - 2));
        if (we) begin
          model_mem[fa] = wdata[8*(w-1-(e-2)) +: 8];
          fsm_w = 1'b1;
        end else begin
          acc[8*(w-1-(e-2)) +: 8] = model_mem[fa];
        end
      end
      if (e == host_edge && !(fsm_w && fa == haddr)) model_mem[haddr] = hdata;
    end
    if (w == 0) last_rd = '0;
    else if (!we) last_rd = acc;
    exp_q.push_back(last_rd);
    lat = w + 1;
  endtask

  // Driver: issue a request, optionally pulse the host port before edge
  // host_edge, wait for ready (bounded) and check data/latency.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] width, input logic [31:0] wdata,
                        input int host_edge, input logic [AW-1:0] haddr,
                        input logic [7:0] hdata, input bit hold_ce);
    int lat;
    int cyc;
    logic [31:0] exp;
    @(negedge clk);
    model_req(we, addr, width, wdata, host_edge, haddr, hdata, lat);
    mem_ce_i    = 1'b1;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_width_i = width;
    mem_data_i  = wdata;
    host_we_i   = (host_edge == 1);
    host_addr_i = haddr;
    host_data_i = hdata;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      host_we_i = (cyc + 1 == host_edge);
      if (mem_ready_o || cyc >= 20) break;
    end
    host_we_i = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    exp = exp_q.pop_front();
    chk({tag, "_data"}, mem_data_o, exp);
    chk({tag, "_busy_at_ready"}, 32'(busy_o), 32'd0);
    if (!hold_ce) begin
      @(negedge clk);
      mem_ce_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_ready_pulse"}, 32'(mem_ready_o), 32'd0);
    end
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we_i   = 1'b1;
    host_addr_i = a;
    host_data_i = d;
    model_mem[a] = d;
    @(negedge clk);
    host_we_i = 1'b0;
  endtask

  initial begin
    int pulses;
    int cyc;
    rst = 1'b0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_width_i = '0; mem_data_i = '0;
    host_we_i = 1'b0; host_addr_i = '0; host_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(mem_ready_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_data", mem_data_o, 32'd0);
    chk("reset_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    // 1: basic big-endian write/read
    do_req("t1_wr", 1'b1, 32'h10, 4'd4, 32'hAABBCCDD, 0, '0, '0, 1'b0);
    do_req("t1_rd4", 1'b0, 32'h10, 4'd4, 32'h0, 0, '0, '0, 1'b0);
    do_req("t1_rd1", 1'b0, 32'h11, 4'd1, 32'h0, 0, '0, '0, 1'b0);

    // 2: address wrap at the top of the RAM
    do_req("t2_wr", 1'b1, 32'(DEPTH - 1), 4'd2, 32'h1234, 0, '0, '0, 1'b0);
    do_req("t2_rd", 1'b0, 32'(DEPTH - 1), 4'd2, 32'h0, 0, '0, '0, 1'b0);
    do_req("t2_rd0", 1'b0, 32'h0, 4'd1, 32'h0, 0, '0, '0, 1'b0);

    // 3: zero width and oversized width
    do_req("t3_w0", 1'b1, 32'h10, 4'd0, 32'hFFFFFFFF, 0, '0, '0, 1'b0);
    do_req("t3_w0_chk", 1'b0, 32'h10, 4'd4, 32'h0, 0, '0, '0, 1'b0);
    do_req("t3_w9", 1'b1, 32'h60, 4'd9, 32'h01020304, 0, '0, '0, 1'b0);
    do_req("t3_w9_chk", 1'b0, 32'h60, 4'd4, 32'h0, 0, '0, '0, 1'b0);

    // 4a: ce held one cycle past ready -> single access
    do_req("t4_wr", 1'b1, 32'h50, 4'd1, 32'h77, 0, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("t4_ready_low", 32'(mem_ready_o), 32'd0);
    @(negedge clk);
    mem_ce_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready_o || busy_o) pulses++;
    end
    chk("t4_no_retrigger", 32'(pulses), 32'd0);

    // 4b: ce still high in IDLE -> second access starts
    do_req("t4_rd_a", 1'b0, 32'h50, 4'd1, 32'h0, 0, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    model_req(1'b0, 32'h50, 4'd1, 32'h0, 0, '0, '0, cyc);
    @(posedge clk);
    #1;
    chk("t4_second_busy", 32'(busy_o), 32'd1);
    cyc = 1;
    while (!mem_ready_o && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t4_second_latency", 32'(cyc), 32'd2);
    chk("t4_second_data", mem_data_o, exp_q.pop_front());
    @(negedge clk);
    mem_ce_i = 1'b0;

    // 5: reset in the middle of a write
    for (int i = 0; i < 4; i++) host_wr(AW'(12'h40 + i), 8'(8'hE0 + i));
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_width_i = 4'd4;
    mem_data_i = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(mem_ready_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_data", mem_data_o, 32'd0);
    model_mem[12'h40] = 8'h11;
    model_mem[12'h41] = 8'h22;
    last_rd = '0;
    mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_req("t5_rd", 1'b0, 32'h40, 4'd4, 32'h0, 0, '0, '0, 1'b0);

    // 6: host/FSM collision, then host write during an unrelated read
    do_req("t6_wr", 1'b1, 32'h10, 4'd4, 32'hA1B2C3D4, 5, 12'h013, 8'h5A, 1'b0);
    do_req("t6_rd", 1'b0, 32'h10, 4'd4, 32'h0, 0, '0, '0, 1'b0);
    do_req("t6_rd_host", 1'b0, 32'h10, 4'd2, 32'h0, 2, 12'h020, 8'h5A, 1'b0);
    do_req("t6_rd20", 1'b0, 32'h20, 4'd1, 32'h0, 0, '0, '0, 1'b0);

    // Random byte-level writes/reads against the model
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      a = 32'($urandom_range(12'h100, 12'h1F0));
      w = 4'($urandom_range(1, 4));
      d = $urandom;
      do_req("rnd_wr", 1'b1, a, w, d, 0, '0, '0, 1'b0);
      do_req("rnd_rd", 1'b0, a, w, 32'h0, 0, '0, '0, 1'b0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
